// File: rtl/shmem_responder_if.sv
// Request/response bundle between SP cores and the shared-memory responder.
// Latency: n/a (wires only).
// Backpressure: cores hold req_valid until the matching gnt bit is seen.
interface shmem_responder_if #(
  parameter int NCORES = 4,
  parameter int DW     = 16
);
  logic [NCORES-1:0]    req_valid;
  logic [NCORES-1:0]    req_we;
  logic [NCORES*DW-1:0] req_addr;
  logic [NCORES*DW-1:0] req_wdata;
  logic [NCORES-1:0]    gnt;
  logic [NCORES-1:0]    rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_err;
  logic                 busy;

  // Core side drives requests and observes grants/responses.
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  gnt, rsp_valid, rsp_data, rsp_err, busy
  );

  // Responder side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output gnt, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/shmem_responder.sv
// Shared scratch memory serving NCORES request ports through a round-robin arbiter.
// Latency: grant is combinational, response (load data / store ack / error) one cycle later.
// Backpressure: one access per cycle; losers keep req_valid high; no grants while clearing (busy).
module shmem_responder #(
  parameter int NCORES = 4,
  parameter int AW     = 8,
  parameter int DW     = 16
) (
  input  logic               clk,
  input  logic               reset,
  shmem_responder_if.slave   bus
);
  localparam int IW    = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {INIT, SERVE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [IW-1:0]     last_gnt_q, last_gnt_d;
  logic              busy_d;

  logic [NCORES-1:0] gnt_d;
  logic              gnt_any;
  logic [IW-1:0]     cand;

  logic              sel_we;
  logic [DW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic              in_range;

  logic [DW-1:0]     mem [DEPTH];

  logic [NCORES-1:0] rsp_valid_q;
  logic [DW-1:0]     rsp_data_q;
  logic              rsp_err_q;

  // State, clear counter and arbitration pointer registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= INIT;
      clr_cnt_q  <= '0;
      last_gnt_q <= IW'(NCORES - 1);
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // INIT sweeps every word once, then hands over to SERVE for good.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = 1'b0;
    case (state_q)
      INIT: begin
        busy_d    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = SERVE;
      end
      SERVE:   state_d = SERVE;
      default: state_d = INIT;
    endcase
  end

  // Round-robin: scan upward from the core after the last winner; only req_valid matters.
  always_comb begin
    gnt_d      = '0;
    gnt_any    = 1'b0;
    last_gnt_d = last_gnt_q;
    cand       = '0;
    if (state_q == SERVE) begin
      for (int k = 1; k <= NCORES; k++) begin
        cand = IW'((int'(last_gnt_q) + k) % NCORES);
        if (!gnt_any && bus.req_valid[cand]) begin
          gnt_any     = 1'b1;
          gnt_d[cand] = 1'b1;
          last_gnt_d  = cand;
        end
      end
    end
  end

  // Mux the winning core's request fields; addresses above the array flag an error.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (gnt_d[i]) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*DW +: DW];
        sel_wdata = bus.req_wdata[i*DW +: DW];
      end
    end
    in_range = (sel_addr[DW-1:AW] == '0);
  end

  // Memory write port: zero-fill during INIT, otherwise in-range granted stores.
  always_ff @(posedge clk) begin
    if (reset && state_q == INIT) begin
      mem[clr_cnt_q] <= '0;
    end else if (reset && gnt_any && sel_we && in_range) begin
      mem[sel_addr[AW-1:0]] <= sel_wdata;
    end
  end

  // Response registers; reset drops any response that would be due next cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= gnt_d;
      rsp_err_q   <= gnt_any && !in_range;
      rsp_data_q  <= (gnt_any && !sel_we && in_range) ? mem[sel_addr[AW-1:0]] : '0;
    end
  end

  assign bus.gnt       = gnt_d;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_d;
endmodule

// File: doc/shmem_responder.md
SHMEM_RESPONDER -- requirements
Module: shmem_responder

Interface
REQ-001 Parameter NCORES, default 4, number of SP core request ports.
REQ-002 Parameter AW, default 8, word-address width of the internal memory; depth is 2^AW words.
REQ-003 Parameter DW, default 16, data and address word width.
REQ-004 clk  input  1  single clock for all state.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req_valid  input  NCORES  per-core request; held stable until granted.
REQ-007 req_we  input  NCORES  per-core write enable: 1 = store, 0 = load.
REQ-008 req_addr  input  NCORES*DW  per-core address; core i occupies bits [i*DW +: DW].
REQ-009 req_wdata  input  NCORES*DW  per-core store data, same packing as req_addr.
REQ-010 gnt  output  NCORES  one-hot combinational grant; the request is consumed at the clock edge where gnt[i]=1.
REQ-011 rsp_valid  output  NCORES  one-hot registered pulse marking completion of the granted access.
REQ-012 rsp_data  output  DW  load data, valid only while a rsp_valid bit is set.
REQ-013 rsp_err  output  1  registered pulse, coincident with rsp_valid, flagging an out-of-range address.
REQ-014 busy  output  1  high while the block is in the INIT state.

Function
REQ-015 The FSM SHALL have two states, INIT and SERVE, and reset SHALL force INIT.
REQ-016 INIT SHALL write 0 to memory address clr_cnt each cycle, clr_cnt counting 0 to 2^AW-1, then transition to SERVE.
REQ-017 INIT SHALL last exactly 2^AW cycles, with busy=1 and gnt=0 throughout.
REQ-018 In SERVE, busy SHALL be 0 and at most one gnt bit SHALL be set per cycle.
REQ-019 Arbitration SHALL be round-robin: search starts at (last_gnt+1) mod NCORES and the first requesting index wins; last_gnt resets to NCORES-1, so core 0 has first priority.
REQ-020 last_gnt SHALL update only on cycles in which a grant occurs.
REQ-021 gnt[i] SHALL depend only on req_valid, last_gnt and state, never on req_addr, req_we or req_wdata.
REQ-022 A granted store with an in-range address SHALL write req_wdata into mem[addr[AW-1:0]] at that clock edge.
REQ-023 A granted load with an in-range address SHALL drive rsp_data = mem[addr[AW-1:0]] in the following cycle.
REQ-024 One cycle after any grant to core i, rsp_valid[i] SHALL be 1, for stores as well as loads.
REQ-025 rsp_valid SHALL be 0 in all other cycles.
REQ-026 An address is out-of-range when addr[DW-1:AW] is nonzero.
REQ-027 For an out-of-range address, a store SHALL be dropped (memory unchanged) and a load SHALL return rsp_data=0; rsp_err=1 with rsp_valid in both cases.
REQ-028 rsp_data SHALL be 0 for store responses and in cycles with no response.
REQ-029 A load issued in the cycle after a store to the same address SHALL return the newly stored data.
REQ-030 Back-to-back grants SHALL be sustained at 1 access per cycle: throughput 1, load latency 1.

Reset
REQ-031 When reset=0 at a clock edge: gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=1, state=INIT, clr_cnt=0, last_gnt=NCORES-1.
REQ-032 Reset mid-INIT SHALL restart clearing at address 0, giving a full 2^AW-cycle INIT after release.
REQ-033 Reset during SERVE SHALL discard any response due in the next cycle (rsp_valid=0) and re-clear the memory.

Verification
REQ-034 Release reset and hold req_valid=0 -> busy=1 for exactly 256 cycles, then 0; a core-0 load of 0x0005 returns rsp_data=0x0000 with rsp_valid[0] one cycle after gnt[0].
REQ-035 Core 0 stores 0xBEEF to 0x0010, then the next cycle core 2 loads 0x0010 -> gnt[0], then gnt[2]; rsp_valid[2] with rsp_data=0xBEEF one cycle later.
REQ-036 All four cores hold continuous load requests -> grant sequence 0,1,2,3,0,1 with one grant per cycle and each rsp_valid[i] one cycle after gnt[i].
REQ-037 Core 1 stores 0x1234 to out-of-range 0x0123 -> gnt[1], then rsp_valid[1]=1 and rsp_err=1; a load of 0x0023 still returns 0x0000.
REQ-038 Assert reset at INIT cycle 100 for one cycle -> busy remains 1 for 256 cycles after release, and no gnt is asserted during that time.
REQ-039 Grant a core-3 load, then assert reset on the following edge -> rsp_valid=0 and rsp_data=0 next cycle, and busy=1.
